// File: rtl/activation_stream.sv
// activation_stream: two-stage streaming activation unit with frame position tracking.
//
// Accepts one pixel position per beat (LANES signed BITWIDTH-bit channels) on a
// valid/ready handshake, applies the frame's activation (pass / ReLU / clipped ReLU /
// leaky ReLU) in S1, and presents the result from S2 together with row/frame markers.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mode, clip_max      activation select and clip bound, sampled on beat (0,0) of a frame
//   in_valid/in_ready   input handshake; in_data carries lane k at [k*BITWIDTH +: BITWIDTH]
//   in_last             upstream end-of-frame marker, checked against internal position
//   out_valid/out_ready output handshake; out_data carries the activated lanes
//   out_row_last        beat is the last column of a row
//   out_last            beat is the last pixel of the frame
//   frame_err           sticky: in_last disagreed with the internal position
//
// Build option: define ACT_LEAKY_EN to implement leaky ReLU on mode 11; otherwise
// mode 11 behaves as ReLU and the shifter is not built.

module activation_stream #(
  parameter int unsigned BITWIDTH    = 32,
  parameter int unsigned LANES       = 2,
  parameter int unsigned ROWS        = 28,
  parameter int unsigned COLS        = 28,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [BITWIDTH-1:0]       clip_max,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BITWIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*BITWIDTH-1:0] out_data,
  output logic                      out_row_last,
  output logic                      out_last,
  output logic                      frame_err
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                      adv, accept;
  logic [RW-1:0]             row_q;
  logic [CW-1:0]             col_q;
  logic                      first_beat, beat_row_last, beat_last;
  logic [1:0]                mode_q, mode_eff;
  logic signed [BITWIDTH-1:0] clip_q, clip_in_eff, clip_eff;
  logic signed [BITWIDTH-1:0] lane_x, lane_y;
  logic [LANES*BITWIDTH-1:0] act_data;

  logic                      s1_valid, s1_row_last, s1_last;
  logic [LANES*BITWIDTH-1:0] s1_data;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  assign first_beat    = (row_q == '0) && (col_q == '0);
  assign beat_row_last = (col_q == CW'(COLS - 1));
  assign beat_last     = beat_row_last && (row_q == RW'(ROWS - 1));

  // A negative clip bound clamps everything positive to zero.
  assign clip_in_eff = clip_max[BITWIDTH-1] ? '0 : $signed(clip_max);

  // Beat (0,0) uses the live controls; the rest of the frame uses the latched copy.
  assign mode_eff = first_beat ? mode : mode_q;
  assign clip_eff = first_beat ? clip_in_eff : clip_q;

  always_comb begin
    act_data = '0;
    lane_x   = '0;
    lane_y   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_x = $signed(in_data[k*BITWIDTH +: BITWIDTH]);
      lane_y = lane_x;
      unique case (mode_eff)
        2'b00: lane_y = lane_x;
        2'b01: lane_y = lane_x[BITWIDTH-1] ? '0 : lane_x;
        2'b10: begin
          if (lane_x[BITWIDTH-1]) lane_y = '0;
          else if (lane_x > clip_eff) lane_y = clip_eff;
          else lane_y = lane_x;
        end
        2'b11: begin
`ifdef ACT_LEAKY_EN
          lane_y = lane_x[BITWIDTH-1] ? (lane_x >>> LEAKY_SHIFT) : lane_x;
`else
          lane_y = lane_x[BITWIDTH-1] ? '0 : lane_x;
`endif
        end
        default: lane_y = lane_x;
      endcase
      act_data[k*BITWIDTH +: BITWIDTH] = lane_y;
    end
  end

`ifndef ACT_LEAKY_EN
  logic unused_leaky_shift;
  assign unused_leaky_shift = ^LEAKY_SHIFT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      mode_q       <= 2'b01;
      clip_q       <= '0;
      frame_err    <= 1'b0;
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_row_last  <= 1'b0;
      s1_last      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row_last <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      if (accept) begin
        if (beat_row_last) begin
          col_q <= '0;
          row_q <= beat_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (first_beat) begin
          mode_q <= mode;
          clip_q <= clip_in_eff;
        end
        // No resync on mismatch: the error is only flagged.
        if (in_last != beat_last) frame_err <= 1'b1;
      end
      if (adv) begin
        s1_valid     <= accept;
        s1_data      <= accept ? act_data : '0;
        s1_row_last  <= accept & beat_row_last;
        s1_last      <= accept & beat_last;
        out_valid    <= s1_valid;
        out_data     <= s1_data;
        out_row_last <= s1_row_last;
        out_last     <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_activation_stream.sv
// Scoreboard bench for activation_stream: the driver pushes hand-computed expected
// beats when the DUT accepts them; an independent monitor pops and compares on output.

module tb_activation_stream;

  localparam int BW    = 32;
  localparam int ROWS  = 28;
  localparam int COLS  = 28;
  localparam int FRAME = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [BW-1:0] clip_max;
  logic          in_valid, in_ready, in_last;
  logic [63:0]   in_data;
  logic          out_valid, out_ready, out_row_last, out_last, frame_err;
  logic [63:0]   out_data;

  activation_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .clip_max     (clip_max),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row_last (out_row_last),
    .out_last     (out_last),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        row_last;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_row = 0, m_col = 0;
  int   acc_last_cyc = 0, out_last_cyc = 0;
  int   row_last_cnt = 0, last_cnt = 0;
  bit   bp_en = 1'b0, gap_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Monitor: all sampling on the falling edge, away from input changes.
  initial begin
    exp_t        e;
    logic [63:0] prev_data;
    logic        prev_rl, prev_l;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_rl    = 1'b0;
    prev_l     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", out_data, prev_data);
          check("stall_markers", 64'({out_row_last, out_last}), 64'({prev_rl, prev_l}));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %0h want none", out_data);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_row_last", 64'(out_row_last), 64'(e.row_last));
            check("out_last", 64'(out_last), 64'(e.last));
            if (out_row_last) row_last_cnt++;
            if (out_last) begin
              last_cnt++;
              out_last_cyc = cyc;
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_rl    = out_row_last;
        prev_l     = out_last;
      end
    end
  end

  // Presents one beat (called at posedge+1) and returns at posedge+1 after acceptance.
  task automatic send(input logic signed [31:0] d0, input logic signed [31:0] d1,
                      input logic signed [31:0] e0, input logic signed [31:0] e1,
                      input bit bad_last);
    bit is_rl, is_l, acc;
    int waits;
    is_rl = (m_col == COLS - 1);
    is_l  = is_rl && (m_row == ROWS - 1);
    if (gap_en) begin
      while ($urandom_range(3, 0) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_data  = {d1, d0};
    in_last  = bad_last ? !is_l : is_l;
    in_valid = 1'b1;
    waits    = 0;
    acc      = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) begin
        @(posedge clk);
        #1;
        waits++;
      end
    end while (!acc && waits < 200);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no in_ready want accept within 200 cycles");
    end else begin
      sb.push_back('{data: {e1, e0}, row_last: is_rl, last: is_l});
      if (is_l) acc_last_cyc = cyc;
      if (is_rl) begin
        m_col = 0;
        m_row = is_l ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    in_valid = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    mode     = 2'b01;
    clip_max = '0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_markers", 64'({out_row_last, out_last}), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Frame 1: ReLU on (+5, -5), full rate.
    mode = 2'b01;
    for (int i = 0; i < FRAME; i++) send(5, -5, 5, 0, 1'b0);
    drain();
    check("f1_row_last_cnt", 64'(row_last_cnt), 64'd28);
    check("f1_last_cnt", 64'(last_cnt), 64'd1);
    check("f1_last_latency", 64'(out_last_cyc - acc_last_cyc), 64'd2);
    check("f1_frame_err", 64'(frame_err), 64'd0);

    // Frame 2: clip at 6.
    mode     = 2'b10;
    clip_max = 32'd6;
    send(7, 6, 6, 6, 1'b0);
    send(-1, 3, 0, 3, 1'b0);
    for (int i = 2; i < FRAME; i++) send(10, -2, 6, 0, 1'b0);

    // Frame 3: negative clip bound acts as 0.
    clip_max = -32'sd4;
    send(9, 9, 0, 0, 1'b0);
    for (int i = 1; i < FRAME; i++) send(2, -7, 0, 0, 1'b0);

    // Frame 4: mode 11.
    mode = 2'b11;
`ifdef ACT_LEAKY_EN
    send(-9, -8, -2, -1, 1'b0);
    send(-1, 12, -1, 12, 1'b0);
    for (int i = 2; i < FRAME; i++) send(-16, 5, -2, 5, 1'b0);
`else
    send(-9, -8, 0, 0, 1'b0);
    send(-1, 12, 0, 12, 1'b0);
    for (int i = 2; i < FRAME; i++) send(-16, 5, 0, 5, 1'b0);
`endif

    // Frame 5: ReLU; switching to pass mid-frame must be ignored.
    mode = 2'b01;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 100) mode = 2'b00;
      send(-3, 4, 0, 4, 1'b0);
    end
    drain();

    // Frames 6-7: pass mode picked up at (0,0), random backpressure and input gaps.
    row_last_cnt = 0;
    last_cnt     = 0;
    send(-3, 7, -3, 7, 1'b0);
    bp_en  = 1'b1;
    gap_en = 1'b1;
    for (int i = 1; i < 2 * FRAME; i++) send(i, -i, i, -i, 1'b0);
    drain();
    bp_en  = 1'b0;
    gap_en = 1'b0;
    check("bp_row_last_cnt", 64'(row_last_cnt), 64'd56);
    check("bp_last_cnt", 64'(last_cnt), 64'd2);
    check("bp_frame_err", 64'(frame_err), 64'd0);

    // Frame 8: bad in_last on beat 500, then reset mid-frame.
    mode = 2'b01;
    for (int i = 0; i < 600; i++) begin
      send(i, -i, i, 0, i == 499);
      if (i == 498) check("err_before", 64'(frame_err), 64'd0);
      if (i == 499) check("err_rise", 64'(frame_err), 64'd1);
      if (i == 599) check("err_sticky", 64'(frame_err), 64'd1);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_markers", 64'({out_row_last, out_last}), 64'd0);
    check("mid_rst_frame_err", 64'(frame_err), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    m_row = 0;
    m_col = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Post-reset frame: last must land on beat 784 again.
    row_last_cnt = 0;
    last_cnt     = 0;
    for (int i = 0; i < FRAME; i++) send(i, -i, i, 0, 1'b0);
    drain();
    check("pr_last_cnt", 64'(last_cnt), 64'd1);
    check("pr_row_last_cnt", 64'(row_last_cnt), 64'd28);
    check("pr_last_latency", 64'(out_last_cyc - acc_last_cyc), 64'd2);
    check("pr_frame_err", 64'(frame_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
